// File: rtl/adc_seq_pkg.sv
// Shared state encoding, command bytes and ASCII helpers for the ADC capture sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    FETCH,
    SEND,
    PACE,
    DRAIN
  } state_t;

  localparam logic [7:0] CMD_START_LC = 8'h73;
  localparam logic [7:0] CMD_START_UC = 8'h53;
  localparam logic [7:0] CMD_ABORT_LC = 8'h78;
  localparam logic [7:0] CMD_ABORT_UC = 8'h58;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_DIGIT = 8'h30;
  localparam logic [7:0] ASCII_ALPHA = 8'h37;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] c;
    if (nib < 4'd10) c = ASCII_DIGIT + {4'h0, nib};
    else             c = ASCII_ALPHA + {4'h0, nib};
    return c;
  endfunction

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// ADC stream, UART rx and UART tx handshakes of the capture sequencer.
interface adc_capture_sequencer_if #(
  parameter int SAMPLE_W = 24
);
  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_valid;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (
    output adc_data, adc_valid, rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  adc_data, adc_valid, rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/adc_capture_sequencer_sample_buffer.sv
// Capture RAM: one write port, registered read port with one cycle of latency, no reset.
module sample_buffer #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 24,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Captures a burst of ADC samples on a UART start command and dumps them as paced
// uppercase hex ASCII lines terminated by LF, CR.
module adc_capture_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_SAMPLES = 1024,
  parameter int SAMPLE_W    = 24,
  parameter int PACE_CYCLES = 5000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  adc_capture_sequencer_if.slave  bus,
  output logic                    busy,
  output logic                    burst_done
);

  localparam int AW        = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int NDIG      = SAMPLE_W / 4;
  localparam int NCHARS    = NDIG + 2;
  localparam int CW        = $clog2(NCHARS);
  localparam int PW        = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;
  localparam int PACE_LAST = (PACE_CYCLES > 0) ? PACE_CYCLES - 1 : 0;

  state_t              state, state_nx;
  logic [AW-1:0]       widx, widx_nx, ridx, ridx_nx;
  logic [CW-1:0]       cidx, cidx_nx;
  logic [PW-1:0]       pace_cnt, pace_nx;
  logic                fetch_ph, fetch_ph_nx;
  logic [SAMPLE_W-1:0] sample_reg, sample_nx, rd_data;
  logic                done_nx, buf_we, advance, rx_ready_q;
  logic                rx_fire, start_cmd, abort_cmd, tx_valid, tx_fire;
  logic                last_char, last_sample, last_widx;
  logic [3:0]          nibble;
  logic [7:0]          tx_char;

  sample_buffer #(.DEPTH(NUM_SAMPLES), .WIDTH(SAMPLE_W), .AW(AW)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (widx),
    .wdata (bus.adc_data),
    .raddr (ridx),
    .rdata (rd_data)
  );

  assign rx_fire     = bus.rx_valid & rx_ready_q;
  assign start_cmd   = rx_fire && (bus.rx_data == CMD_START_LC || bus.rx_data == CMD_START_UC);
  assign abort_cmd   = rx_fire && (bus.rx_data == CMD_ABORT_LC || bus.rx_data == CMD_ABORT_UC);
  assign tx_valid    = (state == SEND) || (state == DRAIN);
  assign tx_fire     = tx_valid & bus.tx_ready;
  assign last_char   = (cidx == CW'(NCHARS - 1));
  assign last_sample = (ridx == AW'(NUM_SAMPLES - 1));
  assign last_widx   = (widx == AW'(NUM_SAMPLES - 1));

  assign busy         = (state != IDLE);
  assign bus.rx_ready = rx_ready_q;
  assign bus.tx_valid = tx_valid;
  assign bus.tx_data  = tx_char;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      widx       <= '0;
      ridx       <= '0;
      cidx       <= '0;
      pace_cnt   <= '0;
      fetch_ph   <= 1'b0;
      sample_reg <= '0;
      burst_done <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state      <= state_nx;
      widx       <= widx_nx;
      ridx       <= ridx_nx;
      cidx       <= cidx_nx;
      pace_cnt   <= pace_nx;
      fetch_ph   <= fetch_ph_nx;
      sample_reg <= sample_nx;
      burst_done <= done_nx;
      rx_ready_q <= 1'b1;
    end
  end

  // A tx handshake always completes before an abort takes effect; the final CR
  // skips the pace gap so burst_done coincides with busy falling.
  always_comb begin
    state_nx    = state;
    widx_nx     = widx;
    ridx_nx     = ridx;
    cidx_nx     = cidx;
    pace_nx     = pace_cnt;
    fetch_ph_nx = fetch_ph;
    sample_nx   = sample_reg;
    done_nx     = 1'b0;
    buf_we      = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: if (start_cmd) begin
        state_nx = CAPTURE;
        widx_nx  = '0;
      end
      CAPTURE: if (abort_cmd) state_nx = IDLE;
      else if (bus.adc_valid) begin
        buf_we = 1'b1;
        if (last_widx) begin
          state_nx    = FETCH;
          ridx_nx     = '0;
          cidx_nx     = '0;
          fetch_ph_nx = 1'b0;
        end else widx_nx = widx + 1'b1;
      end
      FETCH: if (abort_cmd) state_nx = IDLE;
      else if (!fetch_ph) fetch_ph_nx = 1'b1;
      else begin
        fetch_ph_nx = 1'b0;
        sample_nx   = rd_data;
        state_nx    = SEND;
      end
      SEND: if (tx_fire) begin
        if (abort_cmd) state_nx = IDLE;
        else if (last_char && last_sample) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else if (PACE_CYCLES == 0) advance = 1'b1;
        else begin
          state_nx = PACE;
          pace_nx  = '0;
        end
      end else if (abort_cmd) state_nx = DRAIN;
      PACE: if (abort_cmd) state_nx = IDLE;
      else if (pace_cnt == PW'(PACE_LAST)) begin
        pace_nx = '0;
        advance = 1'b1;
      end else pace_nx = pace_cnt + 1'b1;
      DRAIN: if (tx_fire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (advance) begin
      if (last_char) begin
        state_nx    = FETCH;
        ridx_nx     = ridx + 1'b1;
        cidx_nx     = '0;
        fetch_ph_nx = 1'b0;
      end else begin
        state_nx = SEND;
        cidx_nx  = cidx + 1'b1;
      end
    end
  end

  always_comb begin
    nibble = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cidx == CW'(i)) nibble = sample_reg[SAMPLE_W-1-4*i -: 4];
    end
    if (!tx_valid)                         tx_char = 8'h00;
    else if (cidx == CW'(NCHARS - 2))      tx_char = ASCII_LF;
    else if (last_char)                    tx_char = ASCII_CR;
    else                                   tx_char = hex_ascii(nibble);
  end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed bench for adc_capture_sequencer: 4 x 24-bit samples, 3-cycle pacing.
module tb_adc_capture_sequencer;

  localparam int NS = 4;
  localparam int SW = 24;
  localparam int PC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, burst_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bursts = 0;
  int last_drive = 0;
  bit rand_ready = 1'b0;
  logic prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] rxq[$];
  int hsq[$];

  string exp_a = "12AB0F\n\r000000\n\rFFFFFF\n\r9A5C31\n\r";
  string exp_b = "123456\n\r789ABC\n\rDEF012\n\r345678\n\r";
  string exp_c = "000001\n\r000002\n\r000003\n\r000004\n\r";

  adc_capture_sequencer_if #(.SAMPLE_W(SW)) bus();

  adc_capture_sequencer #(.NUM_SAMPLES(NS), .SAMPLE_W(SW), .PACE_CYCLES(PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observe on the falling edge: record accepted bytes, enforce hold-while-stalled.
  always @(negedge clk) begin
    if (!rst_n) prev_hold = 1'b0;
    else begin
      if (prev_hold) begin
        checks++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== prev_data) begin
          errors++;
          $display("[TB] FAIL tx_hold: tx_valid=%b tx_data=%02h, required 1/%02h", bus.tx_valid, bus.tx_data, prev_data);
        end
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
        rxq.push_back(bus.tx_data);
        hsq.push_back(cyc);
      end
      if (burst_done === 1'b1) begin
        bursts++;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL done_busy: busy=%b with burst_done, required 0", busy);
        end
      end
      prev_hold = (bus.tx_valid === 1'b1) && (bus.tx_ready !== 1'b1);
      prev_data = bus.tx_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic feed(input logic [SW-1:0] d);
    bus.adc_data  = d;
    bus.adc_valid = 1'b1;
    last_drive    = cyc;
    tick();
    bus.adc_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy === 1'b1 && n < budget) begin
      tick();
      if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
    tick();
  endtask

  task automatic test_reset();
    bus.adc_data = '0; bus.adc_valid = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.tx_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    checks += 5;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_tx_valid: got %b, required 0", bus.tx_valid); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_tx_data: got %02h, required 00", bus.tx_data); end
    if (bus.rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_rx_ready: got %b, required 0", bus.rx_ready); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b, required 0", busy); end
    if (burst_done !== 1'b0) begin errors++; $display("[TB] FAIL rst_burst_done: got %b, required 0", burst_done); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL rx_ready_release: got %b, required 0", bus.rx_ready); end
    tick();
    checks++;
    if (bus.rx_ready !== 1'b1) begin errors++; $display("[TB] FAIL rx_ready_after: got %b, required 1", bus.rx_ready); end
  endtask

  task automatic test_basic_dump();
    int base, hb, b0, gap;
    logic [7:0] got;
    bus.tx_ready = 1'b1;
    base = rxq.size(); hb = hsq.size(); b0 = bursts;
    send_byte(8'h73);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_busy: got %b, required 1", busy); end
    feed(24'h12AB0F); feed(24'h000000); feed(24'hFFFFFF); feed(24'h9A5C31);
    wait_idle(2000);
    checks++;
    if (rxq.size() != base + exp_a.len()) begin errors++; $display("[TB] FAIL basic_count: got %0d bytes, required %0d", rxq.size() - base, exp_a.len()); end
    for (int i = 0; i < exp_a.len(); i++) begin
      got = (base + i < rxq.size()) ? rxq[base + i] : 8'h00;
      checks++;
      if (got !== exp_a[i]) begin errors++; $display("[TB] FAIL basic_byte[%0d]: got %02h, required %02h", i, got, exp_a[i]); end
    end
    if (hsq.size() >= hb + exp_a.len()) begin
      checks++;
      if (hsq[hb] != last_drive + 3) begin errors++; $display("[TB] FAIL first_latency: got %0d, required %0d", hsq[hb] - last_drive, 3); end
      for (int i = 1; i < exp_a.len(); i++) begin
        gap = hsq[hb + i] - hsq[hb + i - 1];
        checks++;
        if (gap != (((i % 8) == 0) ? PC + 3 : PC + 1)) begin
          errors++; $display("[TB] FAIL gap[%0d]: got %0d, required %0d", i, gap, ((i % 8) == 0) ? PC + 3 : PC + 1);
        end
      end
    end
    checks++;
    if (bursts - b0 != 1) begin errors++; $display("[TB] FAIL basic_bursts: got %0d, required 1", bursts - b0); end
  endtask

  task automatic test_random_ready();
    int base, b0;
    logic [7:0] got;
    base = rxq.size(); b0 = bursts;
    send_byte(8'h53);
    feed(24'h12AB0F); feed(24'h000000); feed(24'hFFFFFF); feed(24'h9A5C31);
    rand_ready = 1'b1;
    wait_idle(4000);
    rand_ready = 1'b0;
    bus.tx_ready = 1'b1;
    checks++;
    if (rxq.size() != base + exp_a.len()) begin errors++; $display("[TB] FAIL rand_count: got %0d bytes, required %0d", rxq.size() - base, exp_a.len()); end
    for (int i = 0; i < exp_a.len(); i++) begin
      got = (base + i < rxq.size()) ? rxq[base + i] : 8'h00;
      checks++;
      if (got !== exp_a[i]) begin errors++; $display("[TB] FAIL rand_byte[%0d]: got %02h, required %02h", i, got, exp_a[i]); end
    end
    checks++;
    if (bursts - b0 != 1) begin errors++; $display("[TB] FAIL rand_bursts: got %0d, required 1", bursts - b0); end
  endtask

  task automatic test_abort_capture();
    int base, b0;
    logic [7:0] got;
    bus.tx_ready = 1'b1;
    base = rxq.size(); b0 = bursts;
    send_byte(8'h73);
    feed(24'hAAAAAA); feed(24'h555555);
    send_byte(8'h78);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_cap_busy: got %b, required 0", busy); end
    repeat (5) tick();
    checks++;
    if (rxq.size() != base) begin errors++; $display("[TB] FAIL abort_cap_tx: got %0d bytes, required 0", rxq.size() - base); end
    send_byte(8'h53);
    feed(24'h123456); feed(24'h789ABC); feed(24'hDEF012); feed(24'h345678);
    wait_idle(2000);
    for (int i = 0; i < exp_b.len(); i++) begin
      got = (base + i < rxq.size()) ? rxq[base + i] : 8'h00;
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("[TB] FAIL restart_byte[%0d]: got %02h, required %02h", i, got, exp_b[i]); end
    end
    checks++;
    if (bursts - b0 != 1) begin errors++; $display("[TB] FAIL restart_bursts: got %0d, required 1", bursts - b0); end
  endtask

  task automatic test_abort_drain();
    int base, b0, n;
    bus.tx_ready = 1'b0;
    base = rxq.size(); b0 = bursts; n = 0;
    send_byte(8'h73);
    feed(24'h12AB0F); feed(24'h000000); feed(24'hFFFFFF); feed(24'h9A5C31);
    while (bus.tx_valid !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (bus.tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_wait: tx_valid=%b, required 1", bus.tx_valid); end
    repeat (4) tick();
    send_byte(8'h58);
    checks += 3;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL drain_busy: got %b, required 1", busy); end
    if (bus.tx_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid: got %b, required 1", bus.tx_valid); end
    if (bus.tx_data !== 8'h31) begin errors++; $display("[TB] FAIL drain_data: got %02h, required 31", bus.tx_data); end
    repeat (5) tick();
    bus.tx_ready = 1'b1;
    tick();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drain_idle: busy=%b, required 0", busy); end
    if (bus.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_release: tx_valid=%b, required 0", bus.tx_valid); end
    repeat (3) tick();
    checks += 3;
    if (rxq.size() != base + 1) begin errors++; $display("[TB] FAIL drain_count: got %0d bytes, required 1", rxq.size() - base); end
    else if (rxq[base] !== 8'h31) begin errors++; $display("[TB] FAIL drain_byte: got %02h, required 31", rxq[base]); end
    if (bursts != b0) begin errors++; $display("[TB] FAIL drain_bursts: got %0d, required 0", bursts - b0); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL drain_stay_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_coincident_start();
    int base;
    logic [7:0] got;
    bus.tx_ready = 1'b1;
    base = rxq.size();
    bus.adc_data  = 24'hAAAAAA;
    bus.adc_valid = 1'b1;
    send_byte(8'h73);
    bus.adc_valid = 1'b0;
    feed(24'h000001); feed(24'h000002); feed(24'h000003); feed(24'h000004);
    wait_idle(2000);
    checks++;
    if (rxq.size() != base + exp_c.len()) begin errors++; $display("[TB] FAIL coinc_count: got %0d bytes, required %0d", rxq.size() - base, exp_c.len()); end
    for (int i = 0; i < exp_c.len(); i++) begin
      got = (base + i < rxq.size()) ? rxq[base + i] : 8'h00;
      checks++;
      if (got !== exp_c[i]) begin errors++; $display("[TB] FAIL coinc_byte[%0d]: got %02h, required %02h", i, got, exp_c[i]); end
    end
  endtask

  task automatic test_reset_mid_dump();
    int base, b0, n;
    logic [7:0] got;
    bus.tx_ready = 1'b1;
    base = rxq.size(); n = 0;
    send_byte(8'h73);
    feed(24'h12AB0F); feed(24'h000000); feed(24'hFFFFFF); feed(24'h9A5C31);
    while (rxq.size() < base + 10 && n < 500) begin tick(); n++; end
    checks++;
    if (rxq.size() < base + 10) begin errors++; $display("[TB] FAIL mid_dump_wait: got %0d bytes, required 10", rxq.size() - base); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL async_tx_valid: got %b, required 0", bus.tx_valid); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %b, required 0", busy); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("[TB] FAIL async_tx_data: got %02h, required 00", bus.tx_data); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    base = rxq.size(); b0 = bursts;
    send_byte(8'h73);
    feed(24'h123456); feed(24'h789ABC); feed(24'hDEF012); feed(24'h345678);
    wait_idle(2000);
    checks++;
    if (rxq.size() != base + exp_b.len()) begin errors++; $display("[TB] FAIL post_rst_count: got %0d bytes, required %0d", rxq.size() - base, exp_b.len()); end
    for (int i = 0; i < exp_b.len(); i++) begin
      got = (base + i < rxq.size()) ? rxq[base + i] : 8'h00;
      checks++;
      if (got !== exp_b[i]) begin errors++; $display("[TB] FAIL post_rst_byte[%0d]: got %02h, required %02h", i, got, exp_b[i]); end
    end
    checks++;
    if (bursts - b0 != 1) begin errors++; $display("[TB] FAIL post_rst_bursts: got %0d, required 1", bursts - b0); end
  endtask

  initial begin
    test_reset();
    test_basic_dump();
    test_random_ready();
    test_abort_capture();
    test_abort_drain();
    test_coincident_start();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
